// File: rtl/tonic_outq_mc_if.sv
// tonic_outq_mc_if: write, link and status bundle for tonic_outq_mc.
// master drives writes and link_avail; slave is the queue.
interface tonic_outq_mc_if #(
  parameter int NUM_CH = 4,
  parameter int FID_W  = 16,
  parameter int SEQ_W  = 32,
  parameter int TXID_W = 8,
  parameter int DEPTH  = 16
) ();
  localparam int CH_W = $clog2(NUM_CH);
  localparam int SZ_W = $clog2(DEPTH) + 1;

  logic [NUM_CH*FID_W-1:0]  w_fid_in;
  logic [NUM_CH*SEQ_W-1:0]  w_seq_in;
  logic [NUM_CH*TXID_W-1:0] w_txid_in;
  logic                     link_avail;
  logic [NUM_CH-1:0]        tx_val;
  logic                     next_val;
  logic [FID_W-1:0]         next_seq_fid_out;
  logic [SEQ_W-1:0]         next_seq_out;
  logic [TXID_W-1:0]        next_seq_tx_id_out;
  logic [CH_W-1:0]          next_ch_out;
  logic [NUM_CH*SZ_W-1:0]   size_out;
  logic [15:0]              drop_cnt_out;

  modport master (
    output w_fid_in, w_seq_in, w_txid_in, link_avail,
    input  tx_val, next_val, next_seq_fid_out, next_seq_out,
    input  next_seq_tx_id_out, next_ch_out, size_out, drop_cnt_out
  );

  modport slave (
    input  w_fid_in, w_seq_in, w_txid_in, link_avail,
    output tx_val, next_val, next_seq_fid_out, next_seq_out,
    output next_seq_tx_id_out, next_ch_out, size_out, drop_cnt_out
  );
endinterface

// File: rtl/tonic_outq_mc.sv
// tonic_outq_mc: per-channel FIFOs drained by a round-robin arbiter.
// Option macro TONIC_OUTQ_STRICT_PRIO_EN: channel 0 gets strict priority.
module tonic_outq_mc #(
  parameter int NUM_CH   = 4,
  parameter int FID_W    = 16,
  parameter int SEQ_W    = 32,
  parameter int TXID_W   = 8,
  parameter int DEPTH    = 16,
  parameter int THRESH   = 12,
  parameter int FID_NONE = 0
) (
  input logic            clk,
  input logic            rst_n,
  tonic_outq_mc_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int AW   = $clog2(DEPTH);
  localparam int SZ_W = AW + 1;

`ifdef TONIC_OUTQ_STRICT_PRIO_EN
  localparam logic [CH_W-1:0] RR_RST = CH_W'(1);
`else
  localparam logic [CH_W-1:0] RR_RST = '0;
`endif

  logic [SZ_W-1:0]   size    [NUM_CH];
  logic [AW-1:0]     rd_ptr  [NUM_CH];
  logic [AW-1:0]     wr_ptr  [NUM_CH];
  logic [FID_W-1:0]  mem_fid [NUM_CH][DEPTH];
  logic [SEQ_W-1:0]  mem_seq [NUM_CH][DEPTH];
  logic [TXID_W-1:0] mem_tx  [NUM_CH][DEPTH];

  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   rr_nxt;
  logic [CH_W-1:0]   win;
  logic              pop_any;
  logic [NUM_CH-1:0] wr_req;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] push;
  logic [CH_W:0]     ndrop;
  logic [16:0]       dsum;
  logic [15:0]       drop_cnt;

  logic              o_val;
  logic [FID_W-1:0]  o_fid;
  logic [SEQ_W-1:0]  o_seq;
  logic [TXID_W-1:0] o_tx;
  logic [CH_W-1:0]   o_ch;

  // Per-channel write request and full flags
  always_comb begin
    wr_req = '0;
    full   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_req[c] = bus.w_fid_in[c*FID_W +: FID_W] != FID_W'(FID_NONE);
      full[c]   = size[c] == SZ_W'(DEPTH);
    end
  end

  // Pick the first non-empty channel at or after rr_ptr
  always_comb begin
    int j;
    j       = 0;
    pop_any = 1'b0;
    win     = '0;
`ifdef TONIC_OUTQ_STRICT_PRIO_EN
    if (size[0] != '0) begin
      pop_any = 1'b1;
    end else begin
      for (int i = 0; i < NUM_CH - 1; i++) begin
        j = int'(rr_ptr) + i;
        if (j >= NUM_CH) j = j - (NUM_CH - 1);
        if (!pop_any && size[j] != '0) begin
          pop_any = 1'b1;
          win     = CH_W'(j);
        end
      end
    end
`else
    for (int i = 0; i < NUM_CH; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!pop_any && size[j] != '0) begin
        pop_any = 1'b1;
        win     = CH_W'(j);
      end
    end
`endif
    if (!bus.link_avail) pop_any = 1'b0;
  end

  // Pointer advance past the winner
  always_comb begin
    rr_nxt = rr_ptr;
`ifdef TONIC_OUTQ_STRICT_PRIO_EN
    if (pop_any && win != '0)
      rr_nxt = (win == CH_W'(NUM_CH - 1)) ? CH_W'(1) : win + 1'b1;
`else
    if (pop_any)
      rr_nxt = (win == CH_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
`endif
  end

  // Pop/push decisions; a full channel accepts a push only when popped
  always_comb begin
    pop   = '0;
    push  = '0;
    ndrop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pop[c]  = pop_any && (win == CH_W'(c));
      push[c] = wr_req[c] && (!full[c] || pop[c]);
      if (wr_req[c] && full[c] && !pop[c]) ndrop = ndrop + 1'b1;
    end
    dsum = {1'b0, drop_cnt} + 17'(ndrop);
  end

  // Queue control state, drop counter and registered output entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= RR_RST;
      drop_cnt <= '0;
      o_val    <= 1'b0;
      o_fid    <= FID_W'(FID_NONE);
      o_seq    <= '0;
      o_tx     <= '0;
      o_ch     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        size[c]   <= '0;
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
      end
    end else begin
      rr_ptr   <= rr_nxt;
      drop_cnt <= dsum[16] ? 16'hFFFF : dsum[15:0];
      if (pop_any) begin
        o_val <= 1'b1;
        o_fid <= mem_fid[win][rd_ptr[win]];
        o_seq <= mem_seq[win][rd_ptr[win]];
        o_tx  <= mem_tx[win][rd_ptr[win]];
        o_ch  <= win;
      end else begin
        o_val <= 1'b0;
        o_fid <= FID_W'(FID_NONE);
        o_seq <= '0;
        o_tx  <= '0;
        o_ch  <= '0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        if (push[c] && !pop[c])
          size[c] <= size[c] + 1'b1;
        else if (pop[c] && !push[c])
          size[c] <= size[c] - 1'b1;
      end
    end
  end

  // Entry storage, never reset
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst_n && push[c]) begin
        mem_fid[c][wr_ptr[c]] <= bus.w_fid_in[c*FID_W +: FID_W];
        mem_seq[c][wr_ptr[c]] <= bus.w_seq_in[c*SEQ_W +: SEQ_W];
        mem_tx[c][wr_ptr[c]]  <= bus.w_txid_in[c*TXID_W +: TXID_W];
      end
    end
  end

  // Occupancy export and threshold backpressure
  always_comb begin
    bus.size_out = '0;
    bus.tx_val   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.size_out[c*SZ_W +: SZ_W] = size[c];
      bus.tx_val[c] = size[c] < SZ_W'(THRESH);
    end
  end

  assign bus.next_val           = o_val;
  assign bus.next_seq_fid_out   = o_fid;
  assign bus.next_seq_out       = o_seq;
  assign bus.next_seq_tx_id_out = o_tx;
  assign bus.next_ch_out        = o_ch;
  assign bus.drop_cnt_out       = drop_cnt;
endmodule

// File: tb/tb_tonic_outq_mc.sv
// tb_tonic_outq_mc: scoreboard bench with a queue-level reference model.
// Directed scenarios followed by randomized traffic.
module tb_tonic_outq_mc;
  localparam int NUM_CH = 4;
  localparam int FID_W  = 16;
  localparam int SEQ_W  = 32;
  localparam int TXID_W = 8;
  localparam int DEPTH  = 16;
  localparam int THRESH = 12;
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int SZ_W   = $clog2(DEPTH) + 1;

  typedef struct {
    logic [FID_W-1:0]  fid;
    logic [SEQ_W-1:0]  seq;
    logic [TXID_W-1:0] tx;
  } ent_t;

  typedef struct {
    logic                   val;
    logic [FID_W-1:0]       fid;
    logic [SEQ_W-1:0]       seq;
    logic [TXID_W-1:0]      tx;
    logic [CH_W-1:0]        ch;
    logic [NUM_CH*SZ_W-1:0] sz;
    logic [15:0]            drop;
    logic [NUM_CH-1:0]      txv;
  } exp_t;

  logic clk;
  logic rst_n;

  tonic_outq_mc_if #(
    .NUM_CH(NUM_CH), .FID_W(FID_W), .SEQ_W(SEQ_W),
    .TXID_W(TXID_W), .DEPTH(DEPTH)
  ) bus ();

  tonic_outq_mc #(
    .NUM_CH(NUM_CH), .FID_W(FID_W), .SEQ_W(SEQ_W),
    .TXID_W(TXID_W), .DEPTH(DEPTH), .THRESH(THRESH),
    .FID_NONE(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ent_t q[NUM_CH][$];
  exp_t exp_q[$];
  int   m_rr;
  int   m_drop;

  logic [NUM_CH*FID_W-1:0]  vf;
  logic [NUM_CH*SEQ_W-1:0]  vs;
  logic [NUM_CH*TXID_W-1:0] vt;

`ifdef TONIC_OUTQ_STRICT_PRIO_EN
  localparam int RR0 = 1;
`else
  localparam int RR0 = 0;
`endif

  task automatic wr(input int c, input int f, input int s, input int t);
    vf[c*FID_W +: FID_W]   = FID_W'(f);
    vs[c*SEQ_W +: SEQ_W]   = SEQ_W'(s);
    vt[c*TXID_W +: TXID_W] = TXID_W'(t);
  endtask

  task automatic step(input logic la, input logic r);
    exp_t e;
    ent_t x;
    int   w;
    @(negedge clk);
    bus.w_fid_in   = vf;
    bus.w_seq_in   = vs;
    bus.w_txid_in  = vt;
    bus.link_avail = la;
    rst_n          = r;
    e = '{default: '0};
    if (!r) begin
      for (int c = 0; c < NUM_CH; c++) q[c].delete();
      m_rr   = RR0;
      m_drop = 0;
    end else begin
      w = -1;
      if (la) begin
`ifdef TONIC_OUTQ_STRICT_PRIO_EN
        if (q[0].size() > 0) w = 0;
        for (int i = 0; i < NUM_CH - 1; i++) begin
          int c;
          c = 1 + (m_rr - 1 + i) % (NUM_CH - 1);
          if (w < 0 && q[c].size() > 0) w = c;
        end
`else
        for (int i = 0; i < NUM_CH; i++) begin
          int c;
          c = (m_rr + i) % NUM_CH;
          if (w < 0 && q[c].size() > 0) w = c;
        end
`endif
      end
      if (w >= 0) begin
        x = q[w].pop_front();
        e.val = 1'b1;
        e.fid = x.fid;
        e.seq = x.seq;
        e.tx  = x.tx;
        e.ch  = CH_W'(w);
`ifdef TONIC_OUTQ_STRICT_PRIO_EN
        if (w != 0) m_rr = 1 + (w % (NUM_CH - 1));
`else
        m_rr = (w + 1) % NUM_CH;
`endif
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (vf[c*FID_W +: FID_W] != '0) begin
          if (q[c].size() < DEPTH) begin
            x.fid = vf[c*FID_W +: FID_W];
            x.seq = vs[c*SEQ_W +: SEQ_W];
            x.tx  = vt[c*TXID_W +: TXID_W];
            q[c].push_back(x);
          end else if (m_drop < 65535) begin
            m_drop++;
          end
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      e.sz[c*SZ_W +: SZ_W] = SZ_W'(q[c].size());
      e.txv[c] = q[c].size() < THRESH;
    end
    e.drop = 16'(m_drop);
    exp_q.push_back(e);
    vf = '0;
    vs = '0;
    vt = '0;
  endtask

  // Scoreboard monitor: compares each cycle's outputs after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.next_val, bus.next_seq_fid_out, bus.next_seq_out,
             bus.next_seq_tx_id_out, bus.next_ch_out} !==
            {e.val, e.fid, e.seq, e.tx, e.ch}) begin
          errors++;
          $display("FAIL out t=%0t: got v=%b f=%h s=%h t=%h c=%0d exp v=%b f=%h s=%h t=%h c=%0d",
            $time, bus.next_val, bus.next_seq_fid_out, bus.next_seq_out,
            bus.next_seq_tx_id_out, bus.next_ch_out,
            e.val, e.fid, e.seq, e.tx, e.ch);
        end
        checks++;
        if (bus.size_out !== e.sz) begin
          errors++;
          $display("FAIL size t=%0t: got %h exp %h", $time, bus.size_out, e.sz);
        end
        checks++;
        if (bus.drop_cnt_out !== e.drop) begin
          errors++;
          $display("FAIL drop t=%0t: got %0d exp %0d", $time, bus.drop_cnt_out, e.drop);
        end
        checks++;
        if (bus.tx_val !== e.txv) begin
          errors++;
          $display("FAIL tx_val t=%0t: got %b exp %b", $time, bus.tx_val, e.txv);
        end
      end
    end
  end

  initial begin
    int la_pct;
    int wr_pct;
    rst_n          = 1'b0;
    vf             = '0;
    vs             = '0;
    vt             = '0;
    bus.w_fid_in   = '0;
    bus.w_seq_in   = '0;
    bus.w_txid_in  = '0;
    bus.link_avail = 1'b0;
    m_rr           = RR0;
    m_drop         = 0;

    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    wr(2, 5, 100, 1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);

    step(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < NUM_CH; c++) wr(c, 16 + k * 4 + c, k, c);
      step(1'b0, 1'b1);
    end
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1);

    step(1'b0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      wr(1, 200 + i, i, i);
      step(1'b0, 1'b1);
    end
    for (int i = 0; i < 18; i++) step(1'b1, 1'b1);

    for (int i = 0; i < 16; i++) begin
      wr(0, 300 + i, i, i);
      step(1'b0, 1'b1);
    end
    wr(0, 400, 77, 7);
    step(1'b1, 1'b1);
    for (int i = 0; i < 18; i++) step(1'b1, 1'b1);

    for (int i = 0; i < 5; i++) begin
      wr(i % NUM_CH, 500 + i, i, i);
      step(1'b0, 1'b1);
    end
    wr(3, 600, 1, 1);
    step(1'b1, 1'b0);
    wr(1, 601, 2, 2);
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

    step(1'b0, 1'b0);
    wr(0, 700, 0, 0);
    wr(1, 710, 0, 0);
    step(1'b0, 1'b1);
    wr(0, 701, 1, 0);
    wr(2, 720, 0, 0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);

    la_pct = 50;
    wr_pct = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        la_pct = $urandom_range(0, 2) * 45 + 5;
        wr_pct = $urandom_range(1, 3) * 20;
      end
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 99) < wr_pct)
          wr(c, $urandom_range(1, 65535), $urandom, $urandom_range(0, 255));
      step($urandom_range(0, 99) < la_pct, $urandom_range(0, 999) != 0);
    end
    for (int i = 0; i < 70; i++) step(1'b1, 1'b1);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tonic_outq_mc.md
Name: tonic_outq_mc

Overview:
- Multi-channel output queue for running several credit-engine instances in parallel.
- Each channel has its own FIFO, written by one credit engine with {fid, seq, tx_id} entries.
- A work-conserving round-robin arbiter drains the channels onto the single link whenever link_avail is high.
- Each channel receives its own tx_val backpressure, driven by a per-channel occupancy threshold.

Parameters:
- NUM_CH, 4, number of channels (2..16); CH_W = clog2(NUM_CH).
- FID_W, 16, flow-id width.
- SEQ_W, 32, sequence-number width.
- TXID_W, 8, transmit-count width.
- DEPTH, 16, entries per channel FIFO (power of 2); SZ_W = clog2(DEPTH)+1.
- THRESH, 12, a channel's tx_val is high while its occupancy is below this value.
- FID_NONE, 0, flow-id value meaning "no entry".

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- w_fid_in  in  NUM_CH*FID_W  per-channel write flow id; channel c occupies bits [c*FID_W +: FID_W]
- w_seq_in  in  NUM_CH*SEQ_W  per-channel write sequence number
- w_txid_in  in  NUM_CH*TXID_W  per-channel write tx id
- link_avail  in  1  link can accept one entry this cycle
- tx_val  out  NUM_CH  per-channel "may produce" flag
- next_val  out  1  output entry valid
- next_seq_fid_out  out  FID_W  output flow id
- next_seq_out  out  SEQ_W  output sequence number
- next_seq_tx_id_out  out  TXID_W  output tx id
- next_ch_out  out  CH_W  channel the output entry came from
- size_out  out  NUM_CH*SZ_W  per-channel occupancy
- drop_cnt_out  out  16  count of writes rejected because a channel was full

Behaviour:
- Write:
  - Channel c writes when w_fid[c] != FID_NONE. There is no separate valid bit.
  - The entry is pushed at the clock edge.
  - If channel c is full and is not being popped in the same cycle, the write is dropped and drop_cnt increments. drop_cnt saturates at 0xFFFF.
  - Writes on several channels in one cycle are dropped or counted independently; drop_cnt adds the number of dropped writes, saturating.
- Read and arbitration:
  - Evaluated when link_avail=1.
  - The candidate set is every channel with size>0 at the start of the cycle.
  - The winner is the first non-empty channel at or after rr_ptr, searching upward with wrap from NUM_CH-1 to 0.
  - The winner is popped. Afterwards rr_ptr = winner+1 mod NUM_CH.
  - If link_avail=0 or all channels are empty: nothing is popped and rr_ptr is held.
- Output timing:
  - Outputs are registered and update on the edge that ends the pop cycle. The popped entry, its channel and next_val=1 appear the cycle after link_avail was sampled.
  - With no pop: next_val=0, fid=FID_NONE, seq=0, tx_id=0, ch=0.
  - next_val equals (next_seq_fid_out != FID_NONE).
- Latency:
  - An entry written at edge t can be popped in cycle t+1 and is visible on the outputs after edge t+1.
  - With an empty queue and link_avail held high, write-to-output latency is 2 cycles.
- Occupancy and backpressure:
  - Simultaneous push and pop on the same channel leaves its size unchanged.
  - When a channel is full and popped in the same cycle, the push is accepted.
  - tx_val[c] = (size[c] < THRESH). It is combinational from the registered size, so it responds 1 cycle after the size changes.
- FIFO pointers wrap modulo DEPTH. Full is size==DEPTH; empty is size==0.
- Reset (rst_n=0 at an edge):
  - All sizes, read/write pointers, rr_ptr and drop_cnt are set to 0.
  - Outputs go to the no-pop values; tx_val = all ones.
  - Reset mid-operation discards all queued entries, and writes presented during the reset cycle are ignored.
  - FIFO storage contents are not reset.

Optional Feature:
- Macro: TONIC_OUTQ_STRICT_PRIO_EN.
- Defined:
  - Channel 0 has strict priority: if it is non-empty and link_avail=1, it wins regardless of rr_ptr.
  - Otherwise round-robin runs over channels 1..NUM_CH-1 only, with rr_ptr ranging over 1..NUM_CH-1 and wrapping from NUM_CH-1 to 1. Its reset value is 1.
  - A channel-0 win does not move rr_ptr.
- Undefined: plain round-robin over all channels, as described above.

Test Plan:
- Single write: ch2 writes fid=5, seq=100, txid=1 at cycle 0, link_avail=1 throughout -> cycle 2 shows next_val=1, fid=5, seq=100, txid=1, ch=2; cycle 3 next_val=0.
- Fairness: preload 3 entries in each of ch0..ch3 with link_avail=0, then hold link_avail=1 -> output channel order 0,1,2,3,0,1,2,3,0,1,2,3, then next_val=0.
- Backpressure: NUM_CH=4, THRESH=12, write ch1 every cycle with link_avail=0 -> tx_val[1] falls the cycle after size reaches 12. Writes 17 and 18 are dropped: drop_cnt=2, size=16.
- Full plus pop: ch0 full (16 entries), ch0 write and pop in the same cycle -> size stays 16, drop_cnt unchanged, the popped entry is the oldest.
- Reset mid-operation: 5 entries queued, assert rst_n=0 for 1 cycle -> next cycle all sizes 0, next_val=0, tx_val=4'b1111, drop_cnt=0; the next write emerges after 2 cycles.
- STRICT_PRIO_EN: preload ch0 with 2 entries and ch1/ch2 with 1 each, link_avail=1 -> order 0,0,1,2. Without the macro -> order 0,1,2,0.
